// File: rtl/rx_serial_7n2_pkg.sv
// Shared constants for the 7N2 serial receiver: FSM encodings, frame width
// and bit-period defaults for the common baud rates at 50 MHz.
package rx_serial_7n2_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_START = 4'd1,
        ST_DATA  = 4'd2,
        ST_STOP  = 4'd3,
        ST_DONE  = 4'd4,
        ST_ERRO  = 4'd5
    } estado_t;

    localparam int DATA_BITS   = 7;
    localparam int IDX_W       = 3;
    localparam int SYNC_STAGES = 2;
    localparam int M_9600      = 5208;
    localparam int M_115200    = 434;

endpackage

// File: rtl/rx_serial_7n2_uc.sv
// Control unit of the 7N2 receiver: frame sequencing FSM that drives the
// datapath strobes (counter clear, shift, load, error set).
module rx_serial_uc
    import rx_serial_7n2_pkg::*;
(
    input  logic    clock,
    input  logic    reset,
    input  logic    rx,
    input  logic    tick,
    input  logic    ultimo_bit,
    output logic    zera_s,
    output logic    inicia,
    output logic    desloca,
    output logic    carrega,
    output logic    seta_erro,
    output estado_t estado
);

    estado_t state_reg;
    estado_t state_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        zera_s     = 1'b0;
        inicia     = 1'b0;
        desloca    = 1'b0;
        carrega    = 1'b0;
        seta_erro  = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                zera_s = 1'b1;
                if (!rx) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                // A line that is high again at mid-start was only a glitch.
                if (tick) begin
                    if (rx) begin
                        state_next = ST_IDLE;
                    end else begin
                        inicia     = 1'b1;
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    desloca = 1'b1;
                    if (ultimo_bit) begin
                        state_next = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_next = rx ? ST_DONE : ST_ERRO;
                end
            end
            ST_DONE: begin
                zera_s     = 1'b1;
                carrega    = 1'b1;
                state_next = ST_IDLE;
            end
            ST_ERRO: begin
                // Wait for the line to recover so a break cannot look like a start bit.
                zera_s    = 1'b1;
                seta_erro = 1'b1;
                if (rx) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign estado = state_reg;

endmodule

// File: rtl/rx_serial_7n2.sv
// 7N2 asynchronous serial receiver: mid-bit sampling, 7-bit character
// reassembly, ready pulse / held data flag and framing error flag.
module rx_serial_7n2
    import rx_serial_7n2_pkg::*;
#(
    parameter int M = M_9600,
    parameter int N = 13
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 entrada_serial,
    input  logic                 limpa,
    output logic [DATA_BITS-1:0] dados_ascii,
    output logic                 pronto,
    output logic                 tem_dado,
    output logic                 erro,
    output logic                 db_entrada_serial,
    output logic                 db_tick,
    output logic [3:0]           db_estado
);

    localparam logic [N-1:0]     TICK_HALF = N'(M / 2 - 1);
    localparam logic [N-1:0]     TICK_FULL = N'(M - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rx;
    logic [N-1:0]           cnt_reg;
    logic                   tick;
    logic [IDX_W-1:0]       idx_reg;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [DATA_BITS-1:0]   dados_reg;
    logic                   tem_dado_reg;
    logic                   erro_reg;
    logic                   zera_s;
    logic                   inicia;
    logic                   desloca;
    logic                   carrega;
    logic                   seta_erro;
    estado_t                estado;

    // Two-flop synchronizer; idles high like the line itself.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], entrada_serial};
        end
    end

    assign rx = sync_reg[SYNC_STAGES-1];

    // Bit-period counter: half period to reach mid-start, full periods after that.
    assign tick = ((estado == ST_START) && (cnt_reg == TICK_HALF)) ||
                  (((estado == ST_DATA) || (estado == ST_STOP)) && (cnt_reg == TICK_FULL));

    always_ff @(posedge clock) begin
        if (reset || zera_s || tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx_reg   <= '0;
            shift_reg <= '0;
        end else if (inicia) begin
            idx_reg <= '0;
        end else if (desloca) begin
            idx_reg   <= idx_reg + 1'b1;
            shift_reg <= {rx, shift_reg[DATA_BITS-1:1]};
        end
    end

    // Set beats clear when a load and limpa coincide.
    always_ff @(posedge clock) begin
        if (reset) begin
            dados_reg    <= '0;
            tem_dado_reg <= 1'b0;
            erro_reg     <= 1'b0;
        end else begin
            if (carrega) begin
                dados_reg <= shift_reg;
            end
            if (carrega) begin
                tem_dado_reg <= 1'b1;
            end else if (limpa) begin
                tem_dado_reg <= 1'b0;
            end
            if (inicia) begin
                erro_reg <= 1'b0;
            end else if (seta_erro) begin
                erro_reg <= 1'b1;
            end
        end
    end

    rx_serial_uc u_uc (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .tick       (tick),
        .ultimo_bit (idx_reg == IDX_LAST),
        .zera_s     (zera_s),
        .inicia     (inicia),
        .desloca    (desloca),
        .carrega    (carrega),
        .seta_erro  (seta_erro),
        .estado     (estado)
    );

    assign dados_ascii       = dados_reg;
    assign pronto            = carrega;
    assign tem_dado          = tem_dado_reg;
    assign erro              = erro_reg;
    assign db_entrada_serial = rx;
    assign db_tick           = tick;
    assign db_estado         = estado;

endmodule

// File: tb/tb_rx_serial_7n2.sv
// Directed bench for rx_serial_7n2 at M=16: valid frames, glitch, framing
// error, back-to-back frames, flag handshake and reset mid-frame.
module tb_rx_serial_7n2;

    localparam int M   = 16;
    localparam int N   = 5;
    localparam int LAT = 2 + M / 2 + 8 * M + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       entrada_serial;
    logic       limpa;
    logic [6:0] dados_ascii;
    logic       pronto;
    logic       tem_dado;
    logic       erro;
    logic       db_entrada_serial;
    logic       db_tick;
    logic [3:0] db_estado;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         pulse_cnt = 0;
    int         last_pronto_cyc = 0;
    logic [6:0] got_q[$];

    rx_serial_7n2 #(.M(M), .N(N)) dut (
        .clock             (clk),
        .reset             (reset),
        .entrada_serial    (entrada_serial),
        .limpa             (limpa),
        .dados_ascii       (dados_ascii),
        .pronto            (pronto),
        .tem_dado          (tem_dado),
        .erro              (erro),
        .db_entrada_serial (db_entrada_serial),
        .db_tick           (db_tick),
        .db_estado         (db_estado)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Record ready pulses and the character visible on the cycle after each.
    initial begin
        logic load_pending;
        load_pending = 1'b0;
        forever begin
            @(negedge clk);
            if (load_pending) got_q.push_back(dados_ascii);
            load_pending = pronto;
            if (pronto) begin
                pulse_cnt++;
                last_pronto_cyc = cyc;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame cycle by cycle; limpa pulses at offset limpa_off,
    // cut stops the frame early, hold_end leaves the last level on the line.
    task automatic send_frame(input logic [6:0] d, input logic stop_val, input int n_stop,
                              input int limpa_off, input int cut, input bit hold_end);
        int len;
        start_cyc = cyc;
        len = (8 + n_stop) * M;
        if (cut >= 0 && cut < len) len = cut;
        for (int i = 0; i < len; i++) begin
            int b;
            b = i / M;
            if (b == 0)      entrada_serial = 1'b0;
            else if (b <= 7) entrada_serial = d[b-1];
            else             entrada_serial = stop_val;
            limpa = (i == limpa_off);
            @(posedge clk);
            #1;
        end
        limpa = 1'b0;
        if (!hold_end) entrada_serial = 1'b1;
        $display("frame d=%02h stop=%0d len=%0d pulses=%0d dados=%02h erro=%0d",
                 d, stop_val, len, pulse_cnt, dados_ascii, erro);
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_dados"},  32'(dados_ascii),       32'h00);
        check({pfx, "_pronto"}, 32'(pronto),            32'h0);
        check({pfx, "_tem"},    32'(tem_dado),          32'h0);
        check({pfx, "_erro"},   32'(erro),              32'h0);
        check({pfx, "_dbrx"},   32'(db_entrada_serial), 32'h1);
        check({pfx, "_dbtick"}, 32'(db_tick),           32'h0);
        check({pfx, "_estado"}, 32'(db_estado),         32'h0);
    endtask

    initial begin
        int p0;
        reset = 1'b1;
        entrada_serial = 1'b1;
        limpa = 1'b0;
        tick_n(3);
        check_reset_values("rst");
        reset = 1'b0;
        tick_n(5);

        // Valid frame 0x41 with latency check
        p0 = pulse_cnt;
        send_frame(7'h41, 1'b1, 2, -1, -1, 1'b0);
        tick_n(3);
        check("v41_pulses", 32'(pulse_cnt - p0), 32'd1);
        check("v41_lat", 32'(last_pronto_cyc - start_cyc), 32'(LAT));
        check("v41_dados", 32'(dados_ascii), 32'h41);
        check("v41_tem", 32'(tem_dado), 32'h1);
        check("v41_erro", 32'(erro), 32'h0);

        // Start glitch: three cycles low
        p0 = pulse_cnt;
        entrada_serial = 1'b0;
        tick_n(3);
        entrada_serial = 1'b1;
        tick_n(2);
        check("gl_in_start", 32'(db_estado), 32'd1);
        tick_n(15);
        $display("glitch estado=%0d pulses=%0d", db_estado, pulse_cnt);
        check("gl_idle", 32'(db_estado), 32'd0);
        check("gl_pulses", 32'(pulse_cnt - p0), 32'd0);
        check("gl_dados", 32'(dados_ascii), 32'h41);
        check("gl_erro", 32'(erro), 32'h0);

        // Framing error: 0x55 with stop held low for two bit times
        p0 = pulse_cnt;
        send_frame(7'h55, 1'b0, 2, -1, -1, 1'b1);
        check("fe_estado", 32'(db_estado), 32'd5);
        check("fe_erro", 32'(erro), 32'h1);
        check("fe_dados", 32'(dados_ascii), 32'h41);
        check("fe_pulses", 32'(pulse_cnt - p0), 32'd0);
        entrada_serial = 1'b1;
        tick_n(4);
        check("fe_idle", 32'(db_estado), 32'd0);
        check("fe_erro_held", 32'(erro), 32'h1);
        send_frame(7'h2A, 1'b1, 2, -1, -1, 1'b0);
        tick_n(3);
        check("v2a_dados", 32'(dados_ascii), 32'h2A);
        check("v2a_erro", 32'(erro), 32'h0);
        check("v2a_lat", 32'(last_pronto_cyc - start_cyc), 32'(LAT));

        // Reset during data bit 3, then a clean 0x33
        p0 = pulse_cnt;
        send_frame(7'h33, 1'b1, 2, -1, 4 * M + 6, 1'b1);
        reset = 1'b1;
        entrada_serial = 1'b1;
        tick_n(1);
        check_reset_values("mid");
        reset = 1'b0;
        tick_n(5);
        check("mid_pulses", 32'(pulse_cnt - p0), 32'd0);
        send_frame(7'h33, 1'b1, 2, -1, -1, 1'b0);
        tick_n(3);
        check("v33_dados", 32'(dados_ascii), 32'h33);
        check("v33_tem", 32'(tem_dado), 32'h1);

        // Back-to-back 0x7F then 0x00, one stop bit between them
        p0 = pulse_cnt;
        got_q.delete();
        send_frame(7'h7F, 1'b1, 1, -1, -1, 1'b0);
        send_frame(7'h00, 1'b1, 2, -1, -1, 1'b0);
        tick_n(3);
        check("b2b_pulses", 32'(pulse_cnt - p0), 32'd2);
        check("b2b_n", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            check("b2b_first", 32'(got_q[0]), 32'h7F);
            check("b2b_second", 32'(got_q[1]), 32'h00);
        end

        // Handshake: limpa coincident with pronto, then one cycle later
        limpa = 1'b1;
        tick_n(1);
        limpa = 1'b0;
        check("hs_clear", 32'(tem_dado), 32'h0);
        send_frame(7'h41, 1'b1, 2, LAT, -1, 1'b0);
        tick_n(2);
        check("hs_same", 32'(tem_dado), 32'h1);
        limpa = 1'b1;
        tick_n(1);
        limpa = 1'b0;
        send_frame(7'h41, 1'b1, 2, LAT + 1, -1, 1'b0);
        tick_n(2);
        check("hs_late", 32'(tem_dado), 32'h0);
        check("hs_dados", 32'(dados_ascii), 32'h41);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
